// File: rtl/mc_controller.sv
// mc_controller: sequencing FSM for the multicycle MIPS-subset core, with req/ready memory handshake.
// Define ILLEGAL_OP_TRAP_EN to trap unlisted opcodes into HALT with a sticky illegal_op flag.
module mc_controller #(
  parameter int OP_WIDTH    = 6,
  parameter int STATE_WIDTH = 4,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_WIDTH-1:0] op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_byte,
  output logic                iord,
  output logic                irwrite,
  output logic                pcwrite,
  output logic [1:0]          pcsrc,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          aluop,
  output logic                regwrite,
  output logic                regdst,
  output logic                memtoreg,
  output logic                retire,
  output logic                mem_err,
  output logic                illegal_op
);

  // state    | meaning
  // FETCH    | instruction read at PC, PC+4 on ready
  // DECODE   | branch target into ALUOut, dispatch on op
  // MEMADR   | effective address rs+imm
  // MEMRD    | data read at ALUOut
  // MEMWB    | MDR to rt
  // MEMWR    | data write at ALUOut
  // RTYPEEX  | rs op rt
  // RTYPEWB  | ALUOut to rd
  // BEQEX    | compare, PC <- ALUOut if zero
  // ADDIEX   | rs + imm
  // ADDIWB   | ALUOut to rt
  // JEX      | PC <- jump target
  // HALT     | dead until reset
  typedef enum logic [STATE_WIDTH-1:0] {
    S_FETCH   = STATE_WIDTH'(0),
    S_DECODE  = STATE_WIDTH'(1),
    S_MEMADR  = STATE_WIDTH'(2),
    S_MEMRD   = STATE_WIDTH'(3),
    S_MEMWB   = STATE_WIDTH'(4),
    S_MEMWR   = STATE_WIDTH'(5),
    S_RTYPEEX = STATE_WIDTH'(6),
    S_RTYPEWB = STATE_WIDTH'(7),
    S_BEQEX   = STATE_WIDTH'(8),
    S_ADDIEX  = STATE_WIDTH'(9),
    S_ADDIWB  = STATE_WIDTH'(10),
    S_JEX     = STATE_WIDTH'(11),
    S_HALT    = STATE_WIDTH'(12)
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_LB    = OP_WIDTH'(6'b100000);
  localparam logic [OP_WIDTH-1:0] OP_SB    = OP_WIDTH'(6'b101000);
  localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);

  localparam bit TO_EN = (MEM_TIMEOUT > 0);
  localparam int CW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          req_state, timeout_hit, mem_err_q;

  assign req_state   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // Last tolerated wait cycle: the edge that ends it lands in HALT.
  assign timeout_hit = TO_EN && req_state && !mem_ready && (wait_cnt == TO_LAST);

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (!TO_EN || mem_ready)
      wait_cnt_nxt = '0;
    else if (req_state)
      wait_cnt_nxt = wait_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_hit)
        mem_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:   if (timeout_hit) state_nxt = S_HALT;
                 else if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB, OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:                   state_nxt = S_RTYPEEX;
          OP_BEQ:                     state_nxt = S_BEQEX;
          OP_ADDI:                    state_nxt = S_ADDIEX;
          OP_J:                       state_nxt = S_JEX;
`ifdef ILLEGAL_OP_TRAP_EN
          default:                    state_nxt = S_HALT;
`else
          default:                    state_nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:  state_nxt = op[3] ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (timeout_hit) state_nxt = S_HALT;
                 else if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWB:   state_nxt = S_FETCH;
      S_MEMWR:   if (timeout_hit) state_nxt = S_HALT;
                 else if (mem_ready) state_nxt = S_FETCH;
      S_RTYPEEX: state_nxt = S_RTYPEWB;
      S_RTYPEWB: state_nxt = S_FETCH;
      S_BEQEX:   state_nxt = S_FETCH;
      S_ADDIEX:  state_nxt = S_ADDIWB;
      S_ADDIWB:  state_nxt = S_FETCH;
      S_JEX:     state_nxt = S_FETCH;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // Every strobe is forced low while reset is asserted, so a reset mid-access drops mem_req at once.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_byte = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    pcsrc    = 2'b00;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    retire   = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        S_DECODE:  alusrcb = 2'b11;
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          mem_byte = (op == OP_LB);
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
          retire   = 1'b1;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          iord     = 1'b1;
          mem_byte = (op == OP_SB);
          retire   = mem_ready;
        end
        S_RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_RTYPEWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
          retire   = 1'b1;
        end
        S_BEQEX: begin
          alusrca = 1'b1;
          aluop   = 2'b01;
          pcsrc   = 2'b01;
          pcwrite = zero;
          retire  = 1'b1;
        end
        S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_ADDIWB: begin
          regwrite = 1'b1;
          retire   = 1'b1;
        end
        S_JEX: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
          retire  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_err = mem_err_q & rst_n;

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q;

  // DECODE only heads for HALT on an unlisted opcode.
  always_ff @(posedge clk) begin
    if (!rst_n)
      illegal_q <= 1'b0;
    else if ((state == S_DECODE) && (state_nxt == S_HALT))
      illegal_q <= 1'b1;
  end

  assign illegal_op = illegal_q & rst_n;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: each instruction is expanded into its expected per-cycle strobe vectors.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [5:0] op;
  logic       mem_req, mem_we, mem_byte, iord, irwrite, pcwrite;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic       alusrca, regwrite, regdst, memtoreg, retire, mem_err, illegal_op;

  mc_controller #(.OP_WIDTH(6), .STATE_WIDTH(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .iord(iord),
    .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .retire(retire), .mem_err(mem_err), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LB = 6'b100000, SB = 6'b101000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  // Vector layout: req we byte iord irw pcw pcsrc[2] asa asb[2] aluop[2] rw rd m2r ret err ill
  localparam int B_REQ = 18, B_WE = 17, B_BYTE = 16, B_IORD = 15, B_IRW = 14, B_PCW = 13;
  localparam int F_PCS = 11, B_ASA = 10, F_ASB = 8, F_ALU = 6;
  localparam int B_RW = 5, B_RD = 4, B_M2R = 3, B_RET = 2, B_ERR = 1, B_ILL = 0;

  typedef struct {
    logic [18:0] v;
    string       tag;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0, n_bad = 0, n_cyc = 0, n_ret = 0, n_seen = 0;
  logic [5:0] nxt_op = '0;
  logic       nxt_zero = 1'b0;
  bit         m_err = 0, m_ill = 0;

  function automatic logic [18:0] f_fetch(input bit rdy);
    logic [18:0] e = '0;
    e[B_REQ] = 1'b1; e[F_ASB +: 2] = 2'b01; e[B_IRW] = rdy; e[B_PCW] = rdy;
    return e;
  endfunction

  function automatic logic [18:0] f_decode();
    logic [18:0] e = '0;
    e[F_ASB +: 2] = 2'b11;
    return e;
  endfunction

  function automatic logic [18:0] f_exec(input logic [1:0] asb, input logic [1:0] alu);
    logic [18:0] e = '0;
    e[B_ASA] = 1'b1; e[F_ASB +: 2] = asb; e[F_ALU +: 2] = alu;
    return e;
  endfunction

  function automatic logic [18:0] f_data(input bit we, input bit byt, input bit ret);
    logic [18:0] e = '0;
    e[B_REQ] = 1'b1; e[B_IORD] = 1'b1; e[B_WE] = we; e[B_BYTE] = byt; e[B_RET] = ret;
    return e;
  endfunction

  function automatic logic [18:0] f_wb(input bit rd, input bit m2r);
    logic [18:0] e = '0;
    e[B_RW] = 1'b1; e[B_RD] = rd; e[B_M2R] = m2r; e[B_RET] = 1'b1;
    return e;
  endfunction

  function automatic logic [18:0] f_beq(input bit z);
    logic [18:0] e = f_exec(2'b00, 2'b01);
    e[F_PCS +: 2] = 2'b01; e[B_PCW] = z; e[B_RET] = 1'b1;
    return e;
  endfunction

  function automatic logic [18:0] f_jmp();
    logic [18:0] e = '0;
    e[F_PCS +: 2] = 2'b10; e[B_PCW] = 1'b1; e[B_RET] = 1'b1;
    return e;
  endfunction

  // One DUT cycle: apply inputs just after the edge, queue what the outputs must be this cycle.
  task automatic cyc(input bit rst, input bit rdy, input logic [18:0] e, input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rst; mem_ready = rdy; op = nxt_op; zero = nxt_zero;
    x.v   = rst ? (e | {17'b0, m_err, m_ill}) : '0;
    x.tag = tag;
    q.push_back(x);
    n_cyc++;
    if (!rst) begin
      m_err = 0;
      m_ill = 0;
    end
  endtask

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input int fw, input int mw, input bit z,
                           input string tag, input int len, input int rets);
    int c0, r0;
    nxt_op = o; nxt_zero = z;
    c0 = n_cyc; r0 = n_ret;
    for (int i = 0; i < fw; i++) cyc(1, 0, f_fetch(0), {tag, "/fetch_wait"});
    cyc(1, 1, f_fetch(1), {tag, "/fetch"});
    cyc(1, 1, f_decode(), {tag, "/decode"});
    case (o)
      LB, LW: begin
        cyc(1, 1, f_exec(2'b10, 2'b00), {tag, "/memadr"});
        for (int i = 0; i < mw; i++) cyc(1, 0, f_data(0, o == LB, 0), {tag, "/rd_wait"});
        cyc(1, 1, f_data(0, o == LB, 0), {tag, "/rd"});
        cyc(1, 1, f_wb(0, 1), {tag, "/memwb"});
      end
      SB, SW: begin
        cyc(1, 1, f_exec(2'b10, 2'b00), {tag, "/memadr"});
        for (int i = 0; i < mw; i++) cyc(1, 0, f_data(1, o == SB, 0), {tag, "/wr_wait"});
        cyc(1, 1, f_data(1, o == SB, 1), {tag, "/wr"});
      end
      RT: begin
        cyc(1, 1, f_exec(2'b00, 2'b10), {tag, "/rtex"});
        cyc(1, 1, f_wb(1, 0), {tag, "/rtwb"});
      end
      BEQ:  cyc(1, 1, f_beq(z), {tag, "/beqex"});
      ADDI: begin
        cyc(1, 1, f_exec(2'b10, 2'b00), {tag, "/addiex"});
        cyc(1, 1, f_wb(0, 0), {tag, "/addiwb"});
      end
      JMP:  cyc(1, 1, f_jmp(), {tag, "/jex"});
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        m_ill = 1;
        cyc(1, 1, '0, {tag, "/halt"});
        cyc(1, 1, '0, {tag, "/halt"});
        cyc(0, 0, '0, {tag, "/reset"});
`endif
      end
    endcase
    @(negedge clk);
    #1;
    check({tag, " cycles"}, n_cyc - c0, len);
    check({tag, " retires"}, n_ret - r0, rets);
  endtask

  always @(negedge clk) begin
    exp_t        x;
    logic [18:0] act;
    if (q.size() > 0) begin
      x   = q.pop_front();
      act = {mem_req, mem_we, mem_byte, iord, irwrite, pcwrite, pcsrc, alusrca, alusrcb,
             aluop, regwrite, regdst, memtoreg, retire, mem_err, illegal_op};
      n_cmp++;
      n_seen++;
      if (act !== x.v) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got %b expected %b", x.tag, n_seen, act, x.v);
      end
      if (retire === 1'b1) n_ret++;
    end
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; op = '0; zero = 1'b0;
    cyc(0, 0, '0, "reset");
    cyc(0, 0, '0, "reset");

    run_instr(ADDI, 0, 0, 0, "addi", 4, 1);
    run_instr(LW,   3, 3, 0, "lw_wait", 11, 1);
    run_instr(BEQ,  0, 0, 1, "beq_taken", 3, 1);
    run_instr(BEQ,  0, 0, 0, "beq_not", 3, 1);
    run_instr(SB,   0, 0, 0, "sb", 4, 1);
    run_instr(LB,   0, 0, 0, "lb", 5, 1);
    run_instr(SW,   1, 2, 0, "sw_wait", 7, 1);
    run_instr(RT,   0, 0, 0, "rtype", 4, 1);
    run_instr(JMP,  0, 0, 0, "jump", 3, 1);
    run_instr(LW,   0, 0, 0, "lw", 5, 1);
`ifdef ILLEGAL_OP_TRAP_EN
    run_instr(BAD,  0, 0, 0, "illegal", 5, 0);
`else
    run_instr(BAD,  0, 0, 0, "illegal", 2, 0);
`endif
    run_instr(ADDI, 0, 0, 0, "addi_after", 4, 1);

    // Reset while a load is waiting on memory.
    nxt_op = LW;
    cyc(1, 1, f_fetch(1), "rstmid/fetch");
    cyc(1, 1, f_decode(), "rstmid/decode");
    cyc(1, 1, f_exec(2'b10, 2'b00), "rstmid/memadr");
    cyc(1, 0, f_data(0, 0, 0), "rstmid/rd_wait");
    cyc(0, 0, '0, "rstmid/reset");
    run_instr(LW, 0, 1, 0, "lw_after_rst", 6, 1);

    // Memory never answers: four wait cycles, then sticky error and HALT.
    nxt_op = ADDI;
    for (int i = 0; i < 4; i++) cyc(1, 0, f_fetch(0), "timeout/fetch_wait");
    m_err = 1;
    for (int i = 0; i < 3; i++) cyc(1, 1, '0, "timeout/halt");
    cyc(0, 1, '0, "timeout/reset");
    run_instr(ADDI, 0, 0, 0, "addi_after_err", 4, 1);

    @(negedge clk);
    #1;
    check("queue drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Main sequencing FSM for the multicycle 32-bit MIPS-subset core.
- Takes the opcode from the instruction register and issues every datapath control strobe each cycle: PC, IR, ALU muxes, register file and memory.
- Its dispatch is consistent with the decoder's next-state mapping (LB/SB/LW/SW→MEMADR, RTYPE, BEQ, ADDI, J).
- Adds a req/ready memory handshake so instruction and data accesses tolerate wait states.

Parameters:
- OP_WIDTH, 6, opcode field width (instr[31:26]).
- STATE_WIDTH, 4, state register width.
- MEM_TIMEOUT, 0, wait-cycle cap before `mem_err` is raised; 0 = unlimited.

Ports:
- clk  in  1  system clock; all flops rising edge.
- rst_n  in  1  synchronous active-low reset.
- op  in  OP_WIDTH  opcode from IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write access.
- mem_byte  out  1  1 = byte access (LB/SB); 0 = word access.
- iord  out  1  address mux: 0 = PC, 1 = ALUOut.
- irwrite  out  1  load IR.
- pcwrite  out  1  unconditional PC load.
- pcsrc  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- alusrca  out  1  0 = PC, 1 = rs.
- alusrcb  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- aluop  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- regwrite  out  1  register file write.
- regdst  out  1  0 = rt, 1 = rd.
- memtoreg  out  1  write-back source is MDR.
- retire  out  1  one-cycle pulse when an instruction completes.
- mem_err  out  1  sticky; memory timeout.
- illegal_op  out  1  sticky; see Optional Feature.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, HALT.
- Reset: while `rst_n` = 0 at a clock edge, state←FETCH, `mem_err`←0, `illegal_op`←0, wait counter←0. All outputs are 0 during any cycle in which `rst_n` is low. A reset mid-access drops `mem_req` in the same cycle.
- Outputs are Moore (decoded from state), except the strobes gated by `mem_ready` or `zero`; those are combinational in the same cycle.
- FETCH:
  - `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00.
  - `irwrite` and `pcwrite` = `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE:
  - `alusrca`=0, `alusrcb`=11, `aluop`=00 (branch target into ALUOut).
  - Next state by `op`: 100000/101000/100011/101011→MEMADR, 000000→RTYPEEX, 000100→BEQEX, 001000→ADDIEX, 000010→JEX, others→FETCH.
- MEMADR:
  - `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - Loads (op[3]=0)→MEMRD; stores→MEMWR.
- MEMRD:
  - `mem_req`=1, `iord`=1, `mem_we`=0, `mem_byte`=(op==LB).
  - Holds until `mem_ready`=1, then→MEMWB.
- MEMWB: `regwrite`=1, `regdst`=0, `memtoreg`=1, `retire`=1; →FETCH.
- MEMWR:
  - `mem_req`=1, `mem_we`=1, `iord`=1, `mem_byte`=(op==SB).
  - On `mem_ready`=1: `retire`=1, →FETCH.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, `aluop`=10; →RTYPEWB.
- RTYPEWB: `regwrite`=1, `regdst`=1, `memtoreg`=0, `retire`=1; →FETCH.
- BEQEX:
  - `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsrc`=01.
  - `pcwrite`=`zero`, `retire`=1; →FETCH.
- ADDIEX: `alusrca`=1, `alusrcb`=10, `aluop`=00; →ADDIWB.
- ADDIWB: `regwrite`=1, `regdst`=0, `memtoreg`=0, `retire`=1; →FETCH.
- JEX: `pcsrc`=10, `pcwrite`=1, `retire`=1; →FETCH.
- Handshake rules:
  - `mem_req`, `iord`, `mem_we` and `mem_byte` stay stable from the first cycle of a request until the cycle `mem_ready`=1 inclusive.
  - `mem_ready` is ignored in states where `mem_req`=0.
- Timeout (MEM_TIMEOUT>0):
  - The wait counter increments each cycle with `mem_req`=1 and `mem_ready`=0, and clears on `mem_ready`=1.
  - When the counter reaches MEM_TIMEOUT: `mem_err`←1, →HALT.
- HALT: all strobes 0; exits only by reset.
- Latency in cycles with zero wait states: LW/LB 5, SW/SB 4, R-type 4, ADDI 4, BEQ 3, J 3.

Optional Feature:
- Macro ILLEGAL_OP_TRAP_EN.
  - Defined: an unlisted opcode in DECODE sets `illegal_op`←1 on the next edge and goes →HALT, with no `retire`.
  - Undefined: an unlisted opcode returns to FETCH silently (no `retire`); `illegal_op` is tied to 0.

Test Plan:
- Reset, then ADDI (op 001000), `mem_ready` always 1 → states FETCH, DECODE, ADDIEX, ADDIWB; `regwrite`=1 with `regdst`=0 in cycle 4; `retire` pulses once; back in FETCH on cycle 5.
- LW (100011) with `mem_ready` low 3 cycles in both FETCH and MEMRD → `mem_req`/`iord`/`mem_byte` held stable; `irwrite` pulses only on the ready cycle; 11 cycles total; `memtoreg`=1 in MEMWB.
- BEQ, once with `zero`=1 and once with `zero`=0 → `pcwrite`=1 and 0 respectively with `pcsrc`=01; 3 cycles each.
- SB (101000) → `mem_we`=1 and `mem_byte`=1 in MEMWR; LB (100000) → `mem_byte`=1 with `mem_we`=0.
- `rst_n` driven low during MEMRD wait → `mem_req`=0 that cycle; state FETCH after the edge; all sticky flags clear.
- Opcode 111111 → with ILLEGAL_OP_TRAP_EN: `illegal_op`=1, HALT, no further `mem_req`. Without the macro: FETCH after DECODE. With MEM_TIMEOUT=4 and `mem_ready` stuck at 0 → `mem_err`=1 after 4 wait cycles, then HALT.
